// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the paddle frame-buffer writer.
package fb_pkg;

    localparam int unsigned SCREEN_X  = 128;
    localparam int unsigned SCREEN_Y  = 96;
    localparam int unsigned AW        = 14;
    localparam int unsigned DW        = 3;
    localparam logic [2:0]  BG_COLOR  = 3'b000;
    localparam logic [2:0]  PAD_COLOR = 3'b111;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StErase,
        StDraw
    } fb_state_e;

endpackage

// File: rtl/paddle_fb_writer_if.sv
// Write-port bundle between the paddle writer and the frame buffer, plus status.
interface paddle_fb_writer_if #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 3,
    parameter int unsigned XW = 7
);

    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          busy;
    logic [XW-1:0] pad_x;

    modport master (
        output mem_px_addr,
        output mem_px_data,
        output px_wr,
        output busy,
        output pad_x
    );

    modport slave (
        input mem_px_addr,
        input mem_px_data,
        input px_wr,
        input busy,
        input pad_x
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running divider: one-cycle tick when the count wraps at TICK_DIV-1.
module frame_tick_gen #(
    parameter int unsigned TICK_DIV = 416667
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned    TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/paddle_fb_writer.sv
// Clears the frame buffer, draws the paddle, then erases/redraws it on button moves.
module paddle_fb_writer #(
    parameter int unsigned       SCREEN_X  = fb_pkg::SCREEN_X,
    parameter int unsigned       SCREEN_Y  = fb_pkg::SCREEN_Y,
    parameter int unsigned       AW        = fb_pkg::AW,
    parameter int unsigned       DW        = fb_pkg::DW,
    parameter int unsigned       PAD_W     = 16,
    parameter int unsigned       PAD_H     = 4,
    parameter int unsigned       PAD_Y     = 88,
    parameter int unsigned       STEP      = 4,
    parameter int unsigned       TICK_DIV  = 416667,
    parameter logic [DW-1:0]     BG_COLOR  = fb_pkg::BG_COLOR,
    parameter logic [DW-1:0]     PAD_COLOR = fb_pkg::PAD_COLOR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_r,
    input  logic                  btn_l,
    paddle_fb_writer_if.master    fb
);

    import fb_pkg::*;

    localparam int unsigned    XW       = $clog2(SCREEN_X);
    localparam int unsigned    CW       = (PAD_W > 1) ? $clog2(PAD_W) : 1;
    localparam int unsigned    RW       = (PAD_H > 1) ? $clog2(PAD_H) : 1;
    localparam logic [AW-1:0]  LAST_PIX = AW'(SCREEN_X * SCREEN_Y - 1);
    localparam logic [CW-1:0]  LAST_COL = CW'(PAD_W - 1);
    localparam logic [RW-1:0]  LAST_ROW = RW'(PAD_H - 1);
    localparam logic [XW:0]    STEP_X   = (XW+1)'(STEP);
    localparam logic [XW:0]    MAX_X    = (XW+1)'(SCREEN_X - PAD_W);
    localparam logic [XW-1:0]  INIT_X   = XW'((SCREEN_X - PAD_W) / 2);

    logic            tick;
    logic [1:0]      r_sync_q, l_sync_q;
    logic            btn_r_s, btn_l_s;
    fb_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [XW-1:0]   pad_x_q, pad_x_d;
    logic [XW-1:0]   new_x_q, new_x_d;
    logic [XW-1:0]   move_x;
    logic [XW:0]     sum_x;
    logic            clr_last, rect_last;
    logic [AW-1:0]   row_abs, rect_addr;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;

    frame_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync_q <= '0;
            l_sync_q <= '0;
        end else begin
            r_sync_q <= {r_sync_q[0], btn_r};
            l_sync_q <= {l_sync_q[0], btn_l};
        end
    end

    assign btn_r_s = r_sync_q[1];
    assign btn_l_s = l_sync_q[1];

    // Target column, clamped to [0, SCREEN_X-PAD_W]; conflicting buttons cancel.
    always_comb begin
        sum_x  = {1'b0, pad_x_q} + STEP_X;
        move_x = pad_x_q;
        if (btn_r_s && !btn_l_s) begin
            move_x = (sum_x > MAX_X) ? MAX_X[XW-1:0] : sum_x[XW-1:0];
        end else if (btn_l_s && !btn_r_s) begin
            move_x = ({1'b0, pad_x_q} >= STEP_X) ? pad_x_q - STEP_X[XW-1:0] : '0;
        end
    end

    assign clr_last  = (cnt_q == LAST_PIX);
    assign rect_last = (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign row_abs   = AW'(PAD_Y) + AW'(row_q);
    assign rect_addr = (row_abs << XW) + AW'(pad_x_q) + AW'(col_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_last)                   state_d = StDraw;
            StIdle:  if (tick && move_x != pad_x_q)  state_d = StErase;
            StErase: if (rect_last)                  state_d = StDraw;
            StDraw:  if (rect_last)                  state_d = StIdle;
            default:                                 state_d = StClear;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        pad_x_d = pad_x_q;
        new_x_d = new_x_q;
        unique case (state_q)
            StClear: cnt_d = cnt_q + AW'(1);
            StIdle: begin
                col_d = '0;
                row_d = '0;
                if (tick) new_x_d = move_x;
            end
            StErase, StDraw: begin
                if (rect_last) begin
                    col_d = '0;
                    row_d = '0;
                end else if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
                if (state_q == StErase && rect_last) pad_x_d = new_x_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pad_x_q <= INIT_X;
            new_x_q <= INIT_X;
        end else begin
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pad_x_q <= pad_x_d;
            new_x_q <= new_x_d;
        end
    end

    // Write port is registered: the strobe lands one cycle after the state that issues it.
    always_comb begin
        wr_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        unique case (state_q)
            StClear: begin
                wr_d   = 1'b1;
                addr_d = cnt_q;
                data_d = BG_COLOR;
            end
            StErase: begin
                wr_d   = 1'b1;
                addr_d = rect_addr;
                data_d = BG_COLOR;
            end
            StDraw: begin
                wr_d   = 1'b1;
                addr_d = rect_addr;
                data_d = PAD_COLOR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign fb.mem_px_addr = addr_q;
    assign fb.mem_px_data = data_q;
    assign fb.px_wr       = wr_q;
    assign fb.busy        = (state_q != StIdle) | wr_q;
    assign fb.pad_x       = pad_x_q;

endmodule
